// File: rtl/fp_expand_if.sv
// Bundle carrying the float triple in, the linear result out, and status.
// Pure wiring, no latency of its own.
// Backpressure is carried on in_ready (upstream side) and out_ready (downstream side).
interface fp_expand_if;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [2:0]  e;
  logic [4:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] d_out;
  logic        busy;

  // Driver side: supplies triples and consumes results.
  modport master (
    output in_valid, s, e, f, out_ready,
    input  in_ready, out_valid, d_out, busy
  );

  // Expander side.
  modport slave (
    input  in_valid, s, e, f, out_ready,
    output in_ready, out_valid, d_out, busy
  );
endinterface

// File: rtl/fp_expand.sv
// Rebuilds a 13-bit two's-complement value from a sign/exponent/significand triple.
// Latency: E+1 cycles from accept edge to out_valid; one left shift per clock.
// Backpressure: result held stable in HOLD until out_ready; in_ready only in IDLE.
module fp_expand (
  input  logic        clk,
  input  logic        rst_n,
  fp_expand_if.slave  io
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SIGN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        s_q, s_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [12:0] mag_q, mag_d;
  logic [12:0] d_out_q, d_out_d;
  logic        out_valid_q, out_valid_d;

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q == SHIFT) || (state_q == SIGN);
  assign io.out_valid = out_valid_q;
  assign io.d_out     = d_out_q;

  // Next-state and datapath: capture, shift E times, apply sign, hold for handshake.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    d_out_d     = d_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          s_d     = io.s;
          mag_d   = {8'b0, io.f};
          cnt_d   = io.e;
          state_d = (io.e != 3'd0) ? SHIFT : SIGN;
        end
      end
      SHIFT: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        // Magnitude never exceeds 0x0F80, so negation cannot overflow 13 bits;
        // negating zero yields zero.
        d_out_d     = s_q ? (~mag_q + 13'd1) : mag_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      cnt_q       <= 3'd0;
      mag_q       <= 13'd0;
      d_out_q     <= 13'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      d_out_q     <= d_out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp_expand.sv
// Directed and sweep checks for fp_expand: values, latency, busy length,
// backpressure stability, and asynchronous reset.
module tb_fp_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_expand_if io();

  fp_expand dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One conversion: accept, wait for result, optionally stall, handshake.
  // With hold set, the next triple is presented during the stall and left
  // asserted so it is accepted right after the handshake.
  task automatic xfer(input logic si, input logic [2:0] ei, input logic [4:0] fi,
                      input logic [12:0] exp, input int stall, input logic hold,
                      input logic ns, input logic [2:0] ne, input logic [4:0] nf);
    int          lat;
    int          busy_cnt;
    bit          seen;
    logic [12:0] held;
    @(negedge clk);
    chk("in_ready_idle", 32'(io.in_ready), 32'd1);
    io.in_valid  = 1'b1;
    io.s         = si;
    io.e         = ei;
    io.f         = fi;
    io.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      io.s = ns;
      io.e = ne;
      io.f = nf;
    end else begin
      io.in_valid = 1'b0;
      io.s = 1'($urandom);
      io.e = 3'($urandom);
      io.f = 5'($urandom);
    end
    chk("in_ready_after_accept", 32'(io.in_ready), 32'd0);
    busy_cnt = io.busy ? 1 : 0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (io.out_valid) begin
        lat  = n;
        seen = 1'b1;
        break;
      end
      chk("in_ready_busy", 32'(io.in_ready), 32'd0);
      if (io.busy) busy_cnt++;
    end
    if (!seen) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      return;
    end
    chk("latency", 32'(lat), 32'(ei) + 32'd1);
    chk("d_out", 32'(io.d_out), 32'(exp));
    chk("busy_cycles", 32'(busy_cnt), 32'(ei) + 32'd1);
    chk("busy_in_hold", 32'(io.busy), 32'd0);
    chk("in_ready_hold", 32'(io.in_ready), 32'd0);
    held = io.d_out;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", 32'(io.out_valid), 32'd1);
      chk("stall_d_out", 32'(io.d_out), 32'(held));
      chk("stall_in_ready", 32'(io.in_ready), 32'd0);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handshake_out_valid", 32'(io.out_valid), 32'd0);
    chk("handshake_in_ready", 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    io.in_valid  = 1'b0;
    io.s         = 1'b0;
    io.e         = 3'd0;
    io.f         = 5'd0;
    io.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_d_out", 32'(io.d_out), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    #10 rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    xfer(1'b0, 3'd0, 5'd5,  13'h0005, 0, 1'b0, 1'b0, 3'd0, 5'd0);
    xfer(1'b0, 3'd7, 5'd31, 13'h0F80, 0, 1'b0, 1'b0, 3'd0, 5'd0);
    xfer(1'b1, 3'd3, 5'd16, 13'h1F80, 1, 1'b0, 1'b0, 3'd0, 5'd0);
    xfer(1'b1, 3'd7, 5'd31, 13'h1080, 0, 1'b0, 1'b0, 3'd0, 5'd0);
    xfer(1'b1, 3'd0, 5'd0,  13'h0000, 2, 1'b0, 1'b0, 3'd0, 5'd0);

    // Backpressure with a second triple waiting.
    xfer(1'b0, 3'd2, 5'd9,  13'h0024, 6, 1'b1, 1'b1, 3'd3, 5'd16);
    xfer(1'b1, 3'd3, 5'd16, 13'h1F80, 0, 1'b0, 1'b0, 3'd0, 5'd0);

    // Asynchronous reset in the middle of a shift sequence.
    @(negedge clk);
    io.in_valid  = 1'b1;
    io.s         = 1'b0;
    io.e         = 3'd6;
    io.f         = 5'd3;
    io.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("pre_reset_busy", 32'(io.busy), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_d_out", 32'(io.d_out), 32'd0);
    chk("mid_rst_busy", 32'(io.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    io.in_valid = 1'b1;
    io.e        = 3'd1;
    io.f        = 5'd7;
    @(posedge clk);
    #1;
    chk("rst_no_accept_busy", 32'(io.busy), 32'd0);
    chk("rst_no_accept_in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk);
    io.in_valid = 1'b0;
    rst_n = 1'b1;
    xfer(1'b0, 3'd1, 5'd1, 13'h0002, 0, 1'b0, 1'b0, 3'd0, 5'd0);

    // Exhaustive sweep against an arithmetic scoreboard.
    for (int si = 0; si < 2; si++) begin
      for (int ei = 0; ei < 8; ei++) begin
        for (int fi = 0; fi < 32; fi++) begin
          v = fi * (1 << ei);
          if (si != 0) v = -v;
          xfer(1'(si), 3'(ei), 5'(fi), v[12:0], int'($urandom_range(0, 3)),
               1'b0, 1'b0, 3'd0, 5'd0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
